// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - opcodes, dispatch class encoding and immediate helpers for the issue stage
package issue_pkg;

  localparam logic [6:0] OP_ALU_R = 7'b0110011;
  localparam logic [6:0] OP_ALU_I = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    CLS_ALU_R  = 3'd0,
    CLS_ALU_I  = 3'd1,
    CLS_BRANCH = 3'd2,
    CLS_JAL    = 3'd3,
    CLS_JALR   = 3'd4,
    CLS_LOAD   = 3'd5,
    CLS_STORE  = 3'd6,
    CLS_UPPER  = 3'd7
  } disp_class_e;

  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'b0};
  endfunction

endpackage

// File: rtl/issue_decode.sv
// rtl/issue_decode.sv - combinational instruction word to class/immediate/register decode
module issue_decode
  import issue_pkg::*;
(
  input  logic [31:0] inst,
  output logic [2:0]  cls,
  output logic        auipc,
  output logic        illegal,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic [31:0] imm
);

  logic [2:0] funct3;
  assign funct3 = inst[14:12];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];

  always_comb begin
    cls = CLS_ALU_R;
    auipc = 1'b0;
    illegal = 1'b0;
    rd = inst[11:7];
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm = '0;
    case (inst[6:0])
      OP_ALU_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_ALU_I: begin
        cls = CLS_ALU_I;
        use_rs1 = 1'b1;
        // shift amounts are unsigned; the upper bits carry SRA select, not sign
        imm = (funct3 == 3'b001 || funct3 == 3'b101) ? {27'b0, inst[24:20]} : imm_i(inst);
      end
      OP_BRANCH: begin
        cls = CLS_BRANCH;
        rd = '0;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm = imm_b(inst);
      end
      OP_JAL: begin
        cls = CLS_JAL;
        imm = imm_j(inst);
      end
      OP_JALR: begin
        cls = CLS_JALR;
        use_rs1 = 1'b1;
        imm = imm_i(inst);
      end
      OP_LOAD: begin
        cls = CLS_LOAD;
        use_rs1 = 1'b1;
        imm = imm_i(inst);
      end
      OP_STORE: begin
        cls = CLS_STORE;
        rd = '0;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm = imm_s(inst);
      end
      OP_LUI: begin
        cls = CLS_UPPER;
        imm = imm_u(inst);
      end
      OP_AUIPC: begin
        cls = CLS_UPPER;
        auipc = 1'b1;
        imm = imm_u(inst);
      end
      default: begin
        illegal = 1'b1;
        rd = '0;
      end
    endcase
  end

endmodule

// File: rtl/issue_dispatch_queue.sv
// rtl/issue_dispatch_queue.sv - fetch FIFO with registered decode/dispatch stage
// Optional stall counters: define ISSUE_PERF_CNT_EN.
module issue_dispatch_queue
  import issue_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int ROB_ID_W = 5,
  parameter int AFULL_SLACK = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       rdy_in,
  input  logic                       flush_in,
  input  logic                       enq_valid_in,
  input  logic [31:0]                enq_inst_in,
  input  logic [31:0]                enq_pc_in,
  input  logic                       enq_rvc_in,
  output logic                       enq_ready_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       overflow_out,
  output logic                       disp_valid_out,
  output logic [2:0]                 disp_class_out,
  output logic                       disp_auipc_out,
  output logic                       disp_illegal_out,
  output logic [2:0]                 disp_funct3_out,
  output logic                       disp_alt_out,
  output logic [4:0]                 disp_rd_out,
  output logic [4:0]                 disp_rs1_out,
  output logic [4:0]                 disp_rs2_out,
  output logic                       disp_use_rs1_out,
  output logic                       disp_use_rs2_out,
  output logic [31:0]                disp_imm_out,
  output logic [31:0]                disp_pc_out,
  output logic                       disp_rvc_out,
  output logic [ROB_ID_W-1:0]        disp_rob_id_out,
  input  logic                       rob_ready_in,
  input  logic                       rs_ready_in,
  input  logic                       lsb_ready_in,
  input  logic [ROB_ID_W-1:0]        rob_tail_id_in,
`ifdef ISSUE_PERF_CNT_EN
  output logic [31:0]                perf_stall_rob_out,
  output logic [31:0]                perf_stall_rs_out,
  output logic [31:0]                perf_stall_lsb_out,
`endif
  output logic                       disp_fire_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0] mem_inst [DEPTH];
  logic [31:0] mem_pc [DEPTH];
  logic        mem_rvc [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] fifo_count, next_count;

  logic fifo_empty, enq_live, stage_load, bypass, pop, push, overflow_hit;
  logic lsb_unit, rob_only, unit_ok;
  logic [31:0] head_inst, head_pc;
  logic head_rvc;

  logic [2:0]  dec_class;
  logic        dec_auipc, dec_illegal, dec_use_rs1, dec_use_rs2;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;

  assign count_out = fifo_count;
  assign fifo_empty = (fifo_count == '0);
  assign enq_live = enq_valid_in & rdy_in & !flush_in;
  assign stage_load = !disp_valid_out | disp_fire_out;
  assign bypass = stage_load & fifo_empty & enq_live;
  assign pop = rdy_in & !flush_in & stage_load & !fifo_empty;
  assign push = enq_live & !bypass & (fifo_count < CNT_W'(DEPTH));
  assign overflow_hit = enq_live & !bypass & (fifo_count == CNT_W'(DEPTH));

  assign lsb_unit = (disp_class_out == CLS_LOAD) || (disp_class_out == CLS_STORE);
  // LUI and illegal words only need a ROB slot
  assign rob_only = disp_illegal_out || (disp_class_out == CLS_UPPER && !disp_auipc_out);
  assign unit_ok = rob_only ? 1'b1 : (lsb_unit ? lsb_ready_in : rs_ready_in);
  assign disp_fire_out = disp_valid_out & rdy_in & !flush_in & rob_ready_in & unit_ok;
  assign disp_rob_id_out = disp_valid_out ? rob_tail_id_in : '0;

  assign head_inst = fifo_empty ? enq_inst_in : mem_inst[rd_ptr];
  assign head_pc = fifo_empty ? enq_pc_in : mem_pc[rd_ptr];
  assign head_rvc = fifo_empty ? enq_rvc_in : mem_rvc[rd_ptr];

  issue_decode u_decode (
    .inst    (head_inst),
    .cls     (dec_class),
    .auipc   (dec_auipc),
    .illegal (dec_illegal),
    .rd      (dec_rd),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .use_rs1 (dec_use_rs1),
    .use_rs2 (dec_use_rs2),
    .imm     (dec_imm)
  );

  always_comb begin
    next_count = fifo_count;
    if (push && !pop) next_count = fifo_count + CNT_W'(1);
    else if (pop && !push) next_count = fifo_count - CNT_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_inst[wr_ptr] <= enq_inst_in;
      mem_pc[wr_ptr] <= enq_pc_in;
      mem_rvc[wr_ptr] <= enq_rvc_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fifo_count <= '0;
      enq_ready_out <= 1'b0;
      overflow_out <= 1'b0;
      disp_valid_out <= 1'b0;
      disp_class_out <= '0;
      disp_auipc_out <= 1'b0;
      disp_illegal_out <= 1'b0;
      disp_funct3_out <= '0;
      disp_alt_out <= 1'b0;
      disp_rd_out <= '0;
      disp_rs1_out <= '0;
      disp_rs2_out <= '0;
      disp_use_rs1_out <= 1'b0;
      disp_use_rs2_out <= 1'b0;
      disp_imm_out <= '0;
      disp_pc_out <= '0;
      disp_rvc_out <= 1'b0;
    end else if (flush_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fifo_count <= '0;
      enq_ready_out <= 1'b1;
      disp_valid_out <= 1'b0;
    end else if (rdy_in) begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= next_count;
      enq_ready_out <= (next_count <= CNT_W'(DEPTH - AFULL_SLACK));
      if (overflow_hit) overflow_out <= 1'b1;
      if (stage_load) begin
        disp_valid_out <= pop | bypass;
        if (pop | bypass) begin
          disp_class_out <= dec_class;
          disp_auipc_out <= dec_auipc;
          disp_illegal_out <= dec_illegal;
          disp_funct3_out <= head_inst[14:12];
          disp_alt_out <= head_inst[30];
          disp_rd_out <= dec_rd;
          disp_rs1_out <= dec_rs1;
          disp_rs2_out <= dec_rs2;
          disp_use_rs1_out <= dec_use_rs1;
          disp_use_rs2_out <= dec_use_rs2;
          disp_imm_out <= dec_imm;
          disp_pc_out <= head_pc;
          disp_rvc_out <= head_rvc;
        end
      end
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic stall_base, stall_rob, stall_rs, stall_lsb;
  assign stall_base = disp_valid_out & rdy_in;
  assign stall_rob = stall_base & !rob_ready_in;
  assign stall_rs = stall_base & rob_ready_in & !rob_only & !lsb_unit & !rs_ready_in;
  assign stall_lsb = stall_base & rob_ready_in & lsb_unit & !lsb_ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      perf_stall_rob_out <= '0;
      perf_stall_rs_out <= '0;
      perf_stall_lsb_out <= '0;
    end else begin
      if (stall_rob && perf_stall_rob_out != '1) perf_stall_rob_out <= perf_stall_rob_out + 1'b1;
      if (stall_rs && perf_stall_rs_out != '1) perf_stall_rs_out <= perf_stall_rs_out + 1'b1;
      if (stall_lsb && perf_stall_lsb_out != '1) perf_stall_lsb_out <= perf_stall_lsb_out + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_dispatch_queue.sv
// tb/tb_issue_dispatch_queue.sv - directed self-checking bench for issue_dispatch_queue
module tb_issue_dispatch_queue;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in, flush_in;
  logic        enq_valid_in;
  logic [31:0] enq_inst_in, enq_pc_in;
  logic        enq_rvc_in;
  logic        enq_ready_out;
  logic [5:0]  count_out;
  logic        overflow_out;
  logic        disp_valid_out;
  logic [2:0]  disp_class_out;
  logic        disp_auipc_out, disp_illegal_out;
  logic [2:0]  disp_funct3_out;
  logic        disp_alt_out;
  logic [4:0]  disp_rd_out, disp_rs1_out, disp_rs2_out;
  logic        disp_use_rs1_out, disp_use_rs2_out;
  logic [31:0] disp_imm_out, disp_pc_out;
  logic        disp_rvc_out;
  logic [4:0]  disp_rob_id_out;
  logic        rob_ready_in, rs_ready_in, lsb_ready_in;
  logic [4:0]  rob_tail_id_in;
  logic        disp_fire_out;

  int n_checks = 0;
  int n_pass = 0;

  issue_dispatch_queue dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .rdy_in           (rdy_in),
    .flush_in         (flush_in),
    .enq_valid_in     (enq_valid_in),
    .enq_inst_in      (enq_inst_in),
    .enq_pc_in        (enq_pc_in),
    .enq_rvc_in       (enq_rvc_in),
    .enq_ready_out    (enq_ready_out),
    .count_out        (count_out),
    .overflow_out     (overflow_out),
    .disp_valid_out   (disp_valid_out),
    .disp_class_out   (disp_class_out),
    .disp_auipc_out   (disp_auipc_out),
    .disp_illegal_out (disp_illegal_out),
    .disp_funct3_out  (disp_funct3_out),
    .disp_alt_out     (disp_alt_out),
    .disp_rd_out      (disp_rd_out),
    .disp_rs1_out     (disp_rs1_out),
    .disp_rs2_out     (disp_rs2_out),
    .disp_use_rs1_out (disp_use_rs1_out),
    .disp_use_rs2_out (disp_use_rs2_out),
    .disp_imm_out     (disp_imm_out),
    .disp_pc_out      (disp_pc_out),
    .disp_rvc_out     (disp_rvc_out),
    .disp_rob_id_out  (disp_rob_id_out),
    .rob_ready_in     (rob_ready_in),
    .rs_ready_in      (rs_ready_in),
    .lsb_ready_in     (lsb_ready_in),
    .rob_tail_id_in   (rob_tail_id_in),
    .disp_fire_out    (disp_fire_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    enq_valid_in = 1'b1;
    enq_inst_in = inst;
    enq_pc_in = pc;
    step();
  endtask

  task automatic do_flush();
    enq_valid_in = 1'b0;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
  endtask

  // word lands in an empty stage; rob ready, rs and lsb blocked
  task automatic run_vec(input string tag, input logic [31:0] inst, input logic [2:0] cls,
                         input logic [31:0] imm, input logic [4:0] rd, input logic ill,
                         input logic fire);
    rob_ready_in = 1'b1;
    rs_ready_in = 1'b0;
    lsb_ready_in = 1'b0;
    push(inst, 32'h200);
    enq_valid_in = 1'b0;
    check({tag, "_class"}, disp_class_out, cls);
    check({tag, "_imm"}, disp_imm_out, imm);
    check({tag, "_rd"}, disp_rd_out, rd);
    check({tag, "_illegal"}, disp_illegal_out, ill);
    check({tag, "_fire"}, disp_fire_out, fire);
    rs_ready_in = 1'b1;
    lsb_ready_in = 1'b1;
    step();
  endtask

  initial begin
    rst_n_in = 1'b0;
    rdy_in = 1'b1;
    flush_in = 1'b0;
    enq_valid_in = 1'b0;
    enq_inst_in = '0;
    enq_pc_in = '0;
    enq_rvc_in = 1'b0;
    rob_ready_in = 1'b1;
    rs_ready_in = 1'b1;
    lsb_ready_in = 1'b1;
    rob_tail_id_in = 5'd5;
    #3;
    check("rst_valid", disp_valid_out, 0);
    check("rst_enq_ready", enq_ready_out, 0);
    check("rst_count", count_out, 0);
    check("rst_overflow", overflow_out, 0);
    #9 rst_n_in = 1'b1;
    step();
    check("rel_enq_ready", enq_ready_out, 1);

    // ADDI x1,x0,5 bypasses into the empty stage
    enq_rvc_in = 1'b1;
    push(32'h00500093, 32'h100);
    enq_valid_in = 1'b0;
    enq_rvc_in = 1'b0;
    check("addi_valid", disp_valid_out, 1);
    check("addi_class", disp_class_out, 1);
    check("addi_imm", disp_imm_out, 5);
    check("addi_rd", disp_rd_out, 1);
    check("addi_use_rs1", disp_use_rs1_out, 1);
    check("addi_use_rs2", disp_use_rs2_out, 0);
    check("addi_pc", disp_pc_out, 32'h100);
    check("addi_rvc", disp_rvc_out, 1);
    check("addi_rob_id", disp_rob_id_out, 5);
    check("addi_count", count_out, 0);
    check("addi_fire", disp_fire_out, 1);
    step();
    check("addi_drained", disp_valid_out, 0);

    // fill with the ROB blocked
    rob_ready_in = 1'b0;
    for (int i = 0; i < 31; i++) push(32'h00000013 | (i << 20), i * 4);
    check("fill_count30", count_out, 30);
    check("fill_ready30", enq_ready_out, 1);
    check("fill_stage_pc", disp_pc_out, 0);
    check("fill_fire", disp_fire_out, 0);
    push(32'h00000013, 32'h7c);
    check("fill_count31", count_out, 31);
    check("fill_ready31", enq_ready_out, 0);
    push(32'h00000013, 32'h80);
    check("fill_count32", count_out, 32);
    check("fill_ovf_pre", overflow_out, 0);
    push(32'h00000013, 32'h84);
    check("fill_count_hold", count_out, 32);
    check("fill_ovf", overflow_out, 1);
    do_flush();
    check("flush1_count", count_out, 0);
    check("flush1_valid", disp_valid_out, 0);
    check("flush1_ovf_sticky", overflow_out, 1);

    // steady push+pop at count 5 across pointer wrap
    for (int j = 0; j < 6; j++) push(32'h00000013 | (j << 20), 32'h1000 + j * 4);
    check("stream_count_init", count_out, 5);
    rob_ready_in = 1'b1;
    for (int m = 1; m <= 100; m++) begin
      push(32'h00000013 | ((m + 5) << 20), 32'h1000 + (m + 5) * 4);
      check("stream_count", count_out, 5);
      check("stream_order", disp_pc_out, 32'h1000 + m * 4);
    end
    do_flush();

    // flush with count 7 and a same-cycle enqueue
    rob_ready_in = 1'b0;
    for (int k = 0; k < 8; k++) push(32'h00000013, 32'h300 + k * 4);
    check("pre_flush_count", count_out, 7);
    flush_in = 1'b1;
    push(32'h00000013, 32'h400);
    flush_in = 1'b0;
    enq_valid_in = 1'b0;
    check("flush_count", count_out, 0);
    check("flush_valid", disp_valid_out, 0);
    check("flush_ovf", overflow_out, 1);
    step();
    check("flush_lost", disp_valid_out, 0);

    // SW x1,4(x2) waits on the LSB
    rob_ready_in = 1'b1;
    rs_ready_in = 1'b1;
    lsb_ready_in = 1'b0;
    push(32'h00112223, 32'h500);
    enq_valid_in = 1'b0;
    check("sw_class", disp_class_out, 6);
    check("sw_imm", disp_imm_out, 4);
    check("sw_rd", disp_rd_out, 0);
    check("sw_use_rs2", disp_use_rs2_out, 1);
    check("sw_nofire", disp_fire_out, 0);
    step();
    check("sw_held", disp_valid_out, 1);
    rdy_in = 1'b0;
    lsb_ready_in = 1'b1;
    #1;
    check("sw_stall_nofire", disp_fire_out, 0);
    rdy_in = 1'b1;
    #1;
    check("sw_fire", disp_fire_out, 1);
    step();
    check("sw_gone", disp_valid_out, 0);

    run_vec("lui", 32'h123452b7, 3'd7, 32'h12345000, 5'd5, 1'b0, 1'b1);
    run_vec("srai", 32'h40725193, 3'd1, 32'd7, 5'd3, 1'b0, 1'b0);
    run_vec("beq", 32'hfe208ce3, 3'd2, 32'hfffffff8, 5'd0, 1'b0, 1'b0);
    run_vec("illegal", 32'hffffffff, 3'd0, 32'd0, 5'd0, 1'b1, 1'b1);

    // async reset between edges
    rob_ready_in = 1'b0;
    push(32'h00500093, 32'h600);
    push(32'h00500093, 32'h604);
    enq_valid_in = 1'b0;
    check("arst_pre_valid", disp_valid_out, 1);
    #2 rst_n_in = 1'b0;
    #1;
    check("arst_valid", disp_valid_out, 0);
    check("arst_count", count_out, 0);
    check("arst_ready", enq_ready_out, 0);
    check("arst_ovf", overflow_out, 0);
    rst_n_in = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
